// File: rtl/pipelined_wallace_multiplier.sv
// Three-stage signed/unsigned multiplier: sign-magnitude conditioning, 3:2 CSA
// reduction of the partial products, then carry-propagate add and sign restore.
module pipelined_wallace_multiplier #(
  parameter int WIDTH = 32,
  parameter int TAG_W = 4
) (
  input  logic                 clock,
  input  logic                 reset_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     in_a,
  input  logic [WIDTH-1:0]     in_b,
  input  logic                 in_signed,
  input  logic                 in_high,
  input  logic [TAG_W-1:0]     in_tag,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [WIDTH-1:0]     out_result,
  output logic [2*WIDTH-1:0]   out_prod,
  output logic                 out_ovf,
  output logic [TAG_W-1:0]     out_tag
);

  localparam int PW = 2 * WIDTH;

  logic             run;
  logic             s1_valid, s2_valid, s3_valid;
  logic             s1_load, s2_load, s3_load;
  logic             accept;

  logic [WIDTH-1:0] s1_abs_a, s1_abs_b;
  logic             s1_neg, s1_signed, s1_high;
  logic [TAG_W-1:0] s1_tag;

  logic [PW-1:0]    s2_sum, s2_carry;
  logic             s2_neg, s2_signed, s2_high;
  logic [TAG_W-1:0] s2_tag;

  logic [WIDTH-1:0] abs_a, abs_b;
  logic             neg;
  logic [PW-1:0]    rows [WIDTH+2];
  logic [PW-1:0]    nxt  [WIDTH+2];
  int               cnt, m;
  logic [PW-1:0]    csa_sum, csa_carry;
  logic [PW-1:0]    cpa, prod_c;
  logic [WIDTH-1:0] result_c;
  logic             ovf_c;

  // Each stage loads when empty or when its successor is loading.
  assign s3_load   = ~s3_valid | out_ready;
  assign s2_load   = ~s2_valid | s3_load;
  assign s1_load   = ~s1_valid | s2_load;
  assign in_ready  = run & s1_load;
  assign accept    = in_valid & in_ready;
  assign out_valid = s3_valid;

  assign abs_a = (in_signed & in_a[WIDTH-1]) ? (~in_a + WIDTH'(1)) : in_a;
  assign abs_b = (in_signed & in_b[WIDTH-1]) ? (~in_b + WIDTH'(1)) : in_b;
  assign neg   = in_signed & (in_a[WIDTH-1] ^ in_b[WIDTH-1]) & (|in_a) & (|in_b);

  // Repeated 3:2 compression until only a sum and a carry row remain.
  always_comb begin
    for (int i = 0; i < WIDTH + 2; i++) begin
      rows[i] = '0;
      nxt[i]  = '0;
    end
    for (int i = 0; i < WIDTH; i++)
      rows[i] = s1_abs_b[i] ? (PW'(s1_abs_a) << i) : '0;
    cnt = WIDTH;
    m   = 0;
    for (int lvl = 0; lvl < WIDTH; lvl++) begin
      if (cnt > 2) begin
        m = 0;
        for (int i = 0; i < WIDTH + 2; i++) nxt[i] = '0;
        for (int j = 0; j < WIDTH; j += 3) begin
          if (j + 2 < cnt) begin
            nxt[m]     = rows[j] ^ rows[j+1] ^ rows[j+2];
            nxt[m+1]   = ((rows[j] & rows[j+1]) | (rows[j] & rows[j+2]) |
                          (rows[j+1] & rows[j+2])) << 1;
            m = m + 2;
          end else if (j < cnt) begin
            nxt[m] = rows[j];
            m = m + 1;
            if (j + 1 < cnt) begin
              nxt[m] = rows[j+1];
              m = m + 1;
            end
          end
        end
        for (int i = 0; i < WIDTH + 2; i++) rows[i] = nxt[i];
        cnt = m;
      end
    end
    csa_sum   = rows[0];
    csa_carry = rows[1];
  end

  assign cpa      = s2_sum + s2_carry;
  assign prod_c   = s2_neg ? (~cpa + PW'(1)) : cpa;
  assign result_c = s2_high ? prod_c[PW-1:WIDTH] : prod_c[WIDTH-1:0];
  assign ovf_c    = s2_signed ? ~((prod_c[PW-1:WIDTH-1] == '0) || (prod_c[PW-1:WIDTH-1] == '1))
                              : |prod_c[PW-1:WIDTH];

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      run        <= 1'b0;
      s1_valid   <= 1'b0;
      s1_abs_a   <= '0;
      s1_abs_b   <= '0;
      s1_neg     <= 1'b0;
      s1_signed  <= 1'b0;
      s1_high    <= 1'b0;
      s1_tag     <= '0;
      s2_valid   <= 1'b0;
      s2_sum     <= '0;
      s2_carry   <= '0;
      s2_neg     <= 1'b0;
      s2_signed  <= 1'b0;
      s2_high    <= 1'b0;
      s2_tag     <= '0;
      s3_valid   <= 1'b0;
      out_prod   <= '0;
      out_result <= '0;
      out_ovf    <= 1'b0;
      out_tag    <= '0;
    end else begin
      run <= 1'b1;
      if (s1_load) begin
        s1_valid <= accept;
        if (accept) begin
          s1_abs_a  <= abs_a;
          s1_abs_b  <= abs_b;
          s1_neg    <= neg;
          s1_signed <= in_signed;
          s1_high   <= in_high;
          s1_tag    <= in_tag;
        end
      end
      if (s2_load) begin
        s2_valid <= s1_valid;
        if (s1_valid) begin
          s2_sum    <= csa_sum;
          s2_carry  <= csa_carry;
          s2_neg    <= s1_neg;
          s2_signed <= s1_signed;
          s2_high   <= s1_high;
          s2_tag    <= s1_tag;
        end
      end
      if (s3_load) begin
        s3_valid <= s2_valid;
        if (s2_valid) begin
          out_prod   <= prod_c;
          out_result <= result_c;
          out_ovf    <= ovf_c;
          out_tag    <= s2_tag;
        end
      end
    end
  end

endmodule
